tournament_selector: RTL and testbench
======================================

// Module: tournament_selector
// PURPOSE
//  Parent-selection stage reading the chromosome memory: on start, runs two tournaments of
//  TOUR_SIZE random samples each; the highest-fitness sample of each becomes parent A / parent B.
//  Drives the memory's read port (rBarw=1, combinational read) and hands the parent pair
//  downstream to the crossover stage over a valid/ready handshake.
// PARAMETERS
//  COUNT       32       chromosome slots in memory; power of 2, 2..65536
//  ADDR_WIDTH  5        log2(COUNT); sample index = low ADDR_WIDTH bits of LFSR
//  DATA_WIDTH  19       chromosome width
//  TOUR_SIZE   4        samples per tournament, 1..16
//  LFSR_SEED   16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clk             in   1           rising-edge clock
//  rst             in   1           synchronous, active-high reset
//  start           in   1           1-cycle request for a parent pair; ignored unless busy=0
//  busy            out  1           1 from cycle after accepted start until handshake completes
//  mem_rBarw       out  1           tied 1 (selector never writes memory)
//  mem_address     out  COUNT       sample index, zero-extended to memory's COUNT-bit address
//  mem_data        in   DATA_WIDTH  memory data_out for mem_address (same cycle)
//  mem_fitness     in   64          memory fitness_out for mem_address (same cycle)
//  parent_valid    out  1           parent pair registered and stable
//  parent_ready    in   1           downstream accepts pair when parent_valid & parent_ready
//  parent_a_data   out  DATA_WIDTH  winner of tournament A
//  parent_a_fit    out  64          its fitness
//  parent_a_addr   out  ADDR_WIDTH  its memory index
//  parent_b_data / parent_b_fit / parent_b_addr   out   same as A, tournament B
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, parent_valid=0, all parent_* outputs 0, mem_address=0,
//    LFSR=LFSR_SEED, sample counter=0. Reset mid-tournament or mid-HOLD aborts; pair is lost.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle when not in reset.
//    mem_address = zero-extended LFSR[ADDR_WIDTH-1:0] in PICK states, 0 otherwise.
//  - FSM: IDLE --start--> PICK_A (TOUR_SIZE cycles) -> PICK_B (TOUR_SIZE cycles) -> HOLD
//    --parent_valid&parent_ready--> IDLE.
//  - Each PICK cycle samples mem_data/mem_fitness at current mem_address. First sample of a
//    tournament loads the best registers unconditionally; later samples replace best only if
//    mem_fitness > best (unsigned, 64-bit, strict): ties keep the earlier sample.
//  - On last PICK_A cycle the winner (incl. that cycle's sample) is registered to parent_a_*;
//    likewise parent_b_* on last PICK_B cycle. Sampling is with replacement; A==B is legal.
//  - Latency: start sampled high at edge N -> parent_valid=1 after edge N+2*TOUR_SIZE+1.
//  - HOLD: parent_valid=1, parent_* stable while parent_ready=0 (unbounded backpressure).
//    Handshake edge: parent_valid->0, busy->0 next cycle; start in that same cycle is ignored
//    (busy still 1); earliest restart is the following cycle.
//  - start while busy=1: ignored, no queuing. parent_ready while parent_valid=0: ignored.
//  - Memory writes by other stages during a tournament are not this block's concern; it reads
//    whatever mem_data/mem_fitness present in the sample cycle.
// STRUCTURE
//  - Shared GA package: FSM state enum (IDLE, PICK_A, PICK_B, HOLD), FITNESS_WIDTH=64,
//    LFSR taps constant, default LFSR_SEED.
//  - One sub-module: ga_lfsr16 (seed param, clk/rst, 16-bit state out); reused by the mutation
//    and crossover-point stages.
//  - Rest (FSM, sample counter, best registers, output registers) in this module.
// TESTING (bench memory model: combinational, fitness[i]=i, data[i]=19'h100+i, COUNT=32, TOUR_SIZE=4)
//  1. rst, then start pulse -> parent_valid high exactly 9 cycles after start edge;
//     parent_a_addr = max of the 4 mem_address values in PICK_A, parent_a_data = 19'h100+that; same for B.
//  2. All fitness = 64'h5 -> parent_a_addr equals first sampled address of PICK_A (tie rule); same B.
//  3. fitness[7]=64'hFFFF_FFFF_FFFF_FFFF, bench forces LFSR seed so address 7 appears in PICK_B
//     only -> parent_b_fit = all-ones, parent_b_addr=7, parent_a_fit < all-ones (unsigned compare).
//  4. parent_ready held 0 for 20 cycles in HOLD -> all parent_* stable, busy=1; ready=1 ->
//     parent_valid=0 next cycle; start in handshake cycle ignored, start one cycle later accepted.
//  5. start pulses during PICK_A and HOLD -> no effect on latency or results.
//  6. rst asserted in 3rd PICK_B cycle -> next cycle all outputs 0, state IDLE, LFSR=LFSR_SEED;
//     a subsequent start reproduces test 1's address sequence exactly.

Source files
------------

// File: rtl/tournament_selector_pkg.sv
// Shared GA definitions: selector FSM states, fitness width and LFSR constants
// used by the selection, mutation and crossover-point stages.
package tournament_selector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PICK_A = 2'd1,
        PICK_B = 2'd2,
        HOLD   = 2'd3
    } ga_state_e;

    localparam int FITNESS_WIDTH = 64;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/tournament_selector_ga_lfsr16.sv
// 16-bit Fibonacci LFSR that free-runs every cycle outside reset.
// Shared random source for the GA stages.
module ga_lfsr16
    import tournament_selector_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/tournament_selector.sv
// Parent selection: two tournaments of TOUR_SIZE random memory samples, the fittest
// sample of each is offered downstream as parent A / parent B over valid/ready.
module tournament_selector
    import tournament_selector_pkg::*;
#(
    parameter int          COUNT      = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 19,
    parameter int          TOUR_SIZE  = 4,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     mem_rBarw,
    output logic [COUNT-1:0]         mem_address,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic [FITNESS_WIDTH-1:0] mem_fitness,
    output logic                     parent_valid,
    input  logic                     parent_ready,
    output logic [DATA_WIDTH-1:0]    parent_a_data,
    output logic [FITNESS_WIDTH-1:0] parent_a_fit,
    output logic [ADDR_WIDTH-1:0]    parent_a_addr,
    output logic [DATA_WIDTH-1:0]    parent_b_data,
    output logic [FITNESS_WIDTH-1:0] parent_b_fit,
    output logic [ADDR_WIDTH-1:0]    parent_b_addr,
    output ga_state_e                fsm_state
);

    // Handshake: a pair transfers on any rising edge where parent_valid & parent_ready.
    // parent_valid is registered and the parent_* fields never change while it is high.

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOUR_SIZE - 1);

    ga_state_e state, next_state;

    logic [15:0]              lfsr;
    logic [CNT_W-1:0]         cnt;
    logic [ADDR_WIDTH-1:0]    sample_addr;
    logic                     in_pick;
    logic                     last_pick;
    logic                     handshake;
    logic                     take;

    logic [DATA_WIDTH-1:0]    best_data, win_data;
    logic [FITNESS_WIDTH-1:0] best_fit,  win_fit;
    logic [ADDR_WIDTH-1:0]    best_addr, win_addr;

    ga_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign sample_addr = ADDR_WIDTH'(lfsr);
    assign in_pick     = (state == PICK_A) || (state == PICK_B);
    assign last_pick   = in_pick && (cnt == LAST_CNT);
    assign handshake   = (state == HOLD) && parent_valid && parent_ready;

    assign mem_rBarw   = 1'b1;
    assign mem_address = in_pick ? COUNT'(sample_addr) : '0;
    assign busy        = (state != IDLE);
    assign fsm_state   = state;

    // First sample of a tournament always wins; later ones must be strictly fitter.
    assign take     = (cnt == '0) || (mem_fitness > best_fit);
    assign win_data = take ? mem_data    : best_data;
    assign win_fit  = take ? mem_fitness : best_fit;
    assign win_addr = take ? sample_addr : best_addr;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = PICK_A;
            PICK_A:  if (last_pick) next_state = PICK_B;
            PICK_B:  if (last_pick) next_state = HOLD;
            HOLD:    if (handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            best_data     <= '0;
            best_fit      <= '0;
            best_addr     <= '0;
            parent_valid  <= 1'b0;
            parent_a_data <= '0;
            parent_a_fit  <= '0;
            parent_a_addr <= '0;
            parent_b_data <= '0;
            parent_b_fit  <= '0;
            parent_b_addr <= '0;
        end else begin
            state <= next_state;

            if (in_pick && !last_pick) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            if (in_pick) begin
                best_data <= win_data;
                best_fit  <= win_fit;
                best_addr <= win_addr;
            end

            if ((state == PICK_A) && last_pick) begin
                parent_a_data <= win_data;
                parent_a_fit  <= win_fit;
                parent_a_addr <= win_addr;
            end

            if ((state == PICK_B) && last_pick) begin
                parent_b_data <= win_data;
                parent_b_fit  <= win_fit;
                parent_b_addr <= win_addr;
            end

            // Valid rises one cycle into HOLD, once both parent registers have settled.
            parent_valid <= (state == HOLD) && !handshake;
        end
    end

endmodule

// File: tb/tb_tournament_selector.sv
// Scoreboard bench for tournament_selector: a cycle-accurate LFSR/tournament model predicts
// each parent pair at start time; a negedge monitor checks addresses, pairs and latency.
`timescale 1ns/1ps
module tb_tournament_selector;
    import tournament_selector_pkg::*;

    localparam int          COUNT = 32;
    localparam int          AW    = 5;
    localparam int          DW    = 19;
    localparam int          TS    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          LAT   = 2 * TS + 1;
    localparam int          GAP   = 2;

    typedef struct packed {
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_data;
        logic [63:0]   a_fit;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_data;
        logic [63:0]   b_fit;
        logic [31:0]   start_cyc;
    } pair_t;

    // clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             parent_ready = 1'b1;
    logic             busy, mem_rBarw, parent_valid;
    logic [COUNT-1:0] mem_address;
    logic [DW-1:0]    mem_data;
    logic [63:0]      mem_fitness;
    logic [DW-1:0]    parent_a_data, parent_b_data;
    logic [63:0]      parent_a_fit, parent_b_fit;
    logic [AW-1:0]    parent_a_addr, parent_b_addr;
    ga_state_e        fsm_state;

    tournament_selector #(
        .COUNT(COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TOUR_SIZE(TS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .mem_rBarw(mem_rBarw), .mem_address(mem_address),
        .mem_data(mem_data), .mem_fitness(mem_fitness),
        .parent_valid(parent_valid), .parent_ready(parent_ready),
        .parent_a_data(parent_a_data), .parent_a_fit(parent_a_fit), .parent_a_addr(parent_a_addr),
        .parent_b_data(parent_b_data), .parent_b_fit(parent_b_fit), .parent_b_addr(parent_b_addr),
        .fsm_state(fsm_state)
    );

    // combinational memory model
    logic [63:0] fit_mem [COUNT];
    always_comb begin
        mem_data    = DW'(19'h100) + DW'(mem_address[AW-1:0]);
        mem_fitness = fit_mem[mem_address[AW-1:0]];
    end

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    pick_from = 1;
    int    pick_to = 0;
    int    done_cnt = 0;
    pair_t exp_q[$];
    pair_t cur;
    bit    have_cur = 1'b0;
    logic [15:0] model_lfsr = SEED;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        model_lfsr <= rst ? SEED : lfsr_next(model_lfsr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sample addresses are the next 2*TS LFSR values; winner is the first
    // sample holding the tournament's maximum fitness.
    function automatic pair_t predict(input logic [15:0] lfsr_now);
        pair_t       p;
        logic [15:0] s;
        logic [63:0] mx;
        int          addr [2*TS];
        int          win  [2];
        s = lfsr_now;
        for (int i = 0; i < 2 * TS; i++) begin
            s = lfsr_next(s);
            addr[i] = int'(s) % COUNT;
        end
        for (int t = 0; t < 2; t++) begin
            mx = '0;
            for (int k = 0; k < TS; k++)
                if (fit_mem[addr[t*TS+k]] > mx) mx = fit_mem[addr[t*TS+k]];
            win[t] = -1;
            for (int k = 0; k < TS; k++)
                if (win[t] < 0 && fit_mem[addr[t*TS+k]] == mx) win[t] = addr[t*TS+k];
        end
        p.a_addr    = AW'(win[0]);
        p.a_data    = DW'(19'h100 + win[0]);
        p.a_fit     = fit_mem[win[0]];
        p.b_addr    = AW'(win[1]);
        p.b_data    = DW'(19'h100 + win[1]);
        p.b_fit     = fit_mem[win[1]];
        p.start_cyc = '0;
        return p;
    endfunction

    // monitor: address sequence every cycle, pair contents and latency while valid
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc >= pick_from && cyc <= pick_to)
                check("mem_address", 64'(mem_address), 64'(model_lfsr[AW-1:0]));
            else
                check("mem_address_idle", 64'(mem_address), 64'd0);
            if (parent_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(parent_valid), 64'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("latency", 64'(cyc - int'(cur.start_cyc)), 64'(LAT));
                    end
                end
                if (have_cur) begin
                    check("a_addr", 64'(parent_a_addr), 64'(cur.a_addr));
                    check("a_data", 64'(parent_a_data), 64'(cur.a_data));
                    check("a_fit", parent_a_fit, cur.a_fit);
                    check("b_addr", 64'(parent_b_addr), 64'(cur.b_addr));
                    check("b_data", 64'(parent_b_data), 64'(cur.b_data));
                    check("b_fit", parent_b_fit, cur.b_fit);
                    check("busy_in_hold", 64'(busy), 64'd1);
                    if (parent_ready) begin
                        have_cur = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    // driver tasks (all called #1 after a rising edge)
    task automatic issue_start();
        pair_t p;
        p = predict(model_lfsr);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        p.start_cyc = 32'(cyc);
        pick_from = cyc;
        pick_to = cyc + 2 * TS - 1;
        exp_q.push_back(p);
    endtask

    task automatic wait_done(input int target, input bit rand_ready);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            if (rand_ready) parent_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        parent_ready = 1'b1;
        check("done_timeout", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!parent_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_timeout", 64'(parent_valid), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(parent_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
        check({tag, "_a_addr"}, 64'(parent_a_addr), 64'd0);
        check({tag, "_a_data"}, 64'(parent_a_data), 64'd0);
        check({tag, "_a_fit"}, parent_a_fit, 64'd0);
        check({tag, "_b_addr"}, 64'(parent_b_addr), 64'd0);
        check({tag, "_b_data"}, 64'(parent_b_data), 64'd0);
        check({tag, "_b_fit"}, parent_b_fit, 64'd0);
        check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        check({tag, "_rbarw"}, 64'(mem_rBarw), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pair_t p;
        bit    found;
        for (int i = 0; i < COUNT; i++) fit_mem[i] = 64'(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // 1: fitness = index
        repeat (GAP) @(posedge clk);
        #1 issue_start();
        wait_done(1, 1'b0);

        // 2: all ties, earliest sample wins
        for (int i = 0; i < COUNT; i++) fit_mem[i] = 64'h5;
        repeat (3) @(posedge clk);
        #1 issue_start();
        wait_done(2, 1'b0);

        // 3: address 7 is all-ones and must appear only in tournament B
        for (int i = 0; i < COUNT; i++) fit_mem[i] = 64'(i);
        fit_mem[7] = '1;
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            p = predict(model_lfsr);
            if (p.b_addr == AW'(7) && p.a_addr != AW'(7)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t3_found_timing", 64'(found), 64'd1);
        parent_ready = 1'b0;
        issue_start();
        wait_valid();
        check("t3_b_fit_ones", parent_b_fit, '1);
        check("t3_b_addr7", 64'(parent_b_addr), 64'd7);
        check("t3_a_fit_less", 64'(parent_a_fit < 64'hFFFF_FFFF_FFFF_FFFF), 64'd1);
        parent_ready = 1'b1;
        wait_done(3, 1'b0);

        // 4: long backpressure, start in handshake cycle ignored, next cycle accepted
        parent_ready = 1'b0;
        issue_start();
        wait_valid();
        repeat (20) @(posedge clk);
        #1 check("t4_busy_hold", 64'(busy), 64'd1);
        parent_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_valid_drop", 64'(parent_valid), 64'd0);
        check("t4_busy_drop", 64'(busy), 64'd0);
        check("t4_ignored_start", 64'(fsm_state), 64'(IDLE));
        issue_start();
        check("t4_restart_busy", 64'(busy), 64'd1);
        wait_done(5, 1'b0);

        // 5: start pulses during PICK_A and HOLD have no effect
        parent_ready = 1'b0;
        issue_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 parent_ready = 1'b1;
        wait_done(6, 1'b0);
        repeat (15) @(posedge clk);
        #1 check("t5_idle_after", 64'(busy), 64'd0);

        // 6: reset in the 3rd PICK_B cycle, then test 1's sequence again
        for (int i = 0; i < COUNT; i++) fit_mem[i] = 64'(i);
        issue_start();
        repeat (TS + 2) @(posedge clk);
        #1 rst = 1'b1;
        pick_to = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        check_all_zero("t6_abort");
        repeat (GAP) @(posedge clk);
        #1 issue_start();
        wait_done(7, 1'b0);

        // random fitness tables, random gaps, random backpressure
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < COUNT; i++)
                fit_mem[i] = (r % 2 == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1 issue_start();
            wait_done(8 + r, 1'b1);
        end

        repeat (5) @(posedge clk);
        #1 check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
